// File: rtl/result_streamer.sv
// -----------------------------------------------------------------------------
// result_streamer
//
// Drains the packed 3x3 product matrix of the matrix-multiplication block and
// streams it out as bytes over a valid/ready handshake. One frame is captured
// per rising edge of mult_done. Element 0 goes out first, low byte of each
// element first.
//
// Optional feature: define RESULT_CHECKSUM_EN to append one extra byte per
// frame. That byte is the XOR of all data bytes in the frame.
//
// Parameters:
//   N_ELEM     number of result elements per frame (default 9)
//   ELEM_W     element width in bits, multiple of 8 (default 16)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mult_done  multiplier done level; a 0->1 edge starts a frame
//   result     packed result, element e at [e*ELEM_W +: ELEM_W]
//   out_data   stream byte
//   out_valid  out_data holds a valid byte
//   out_ready  sink accepts the byte this cycle
//   busy       frame captured and not yet fully sent
//   frame_done one-cycle pulse after the last byte is accepted
//   overrun    sticky; a done edge arrived while busy (cleared by rst only)
// -----------------------------------------------------------------------------
module result_streamer #(
  parameter int N_ELEM = 9,
  parameter int ELEM_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mult_done,
  input  logic [N_ELEM*ELEM_W-1:0] result,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int RES_W   = N_ELEM * ELEM_W;
  localparam int N_BYTES = RES_W / 8;
  // Index must be able to hold N_BYTES (one past the last byte).
  localparam int IDX_W   = $clog2(N_BYTES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

`ifdef RESULT_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t             state_r;
  state_t             state_nxt_s;
  logic               done_q_r;
  logic               start_s;
  logic               xfer_s;
  logic [RES_W-1:0]   shadow_r;
  logic [RES_W-1:0]   shadow_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic               overrun_r;
  logic               overrun_nxt_s;
  logic [7:0]         out_data_r;
  logic [7:0]         out_data_nxt_s;
  logic               out_valid_r;
  logic               out_valid_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic               frame_done_r;
  logic               frame_done_nxt_s;
`ifdef RESULT_CHECKSUM_EN
  logic [7:0]         csum_r;
  logic [7:0]         csum_nxt_s;
`endif

  // Select byte k of the shadow vector; indices outside the frame read as 0.
  function automatic logic [7:0] byte_sel(input logic [RES_W-1:0] vec,
                                          input logic [IDX_W-1:0] k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < N_BYTES; i++) begin
      if (k == IDX_W'(i)) begin
        b = vec[8*i +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

`ifdef RESULT_CHECKSUM_EN
  // Fold one byte into the running XOR checksum.
  function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                             input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign start_s = mult_done & ~done_q_r;
  // out_valid is registered, so the transfer never loops back through out_ready.
  assign xfer_s  = out_valid_r & out_ready;

  // Next-state, index, capture and checksum logic.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    shadow_nxt_s  = shadow_r;
    overrun_nxt_s = overrun_r;
`ifdef RESULT_CHECKSUM_EN
    csum_nxt_s    = csum_r;
`endif

    // A new done edge while a frame is still in flight is dropped and flagged.
    if (start_s && (state_r != IDLE)) begin
      overrun_nxt_s = 1'b1;
    end else begin
      overrun_nxt_s = overrun_r;
    end

    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s  = SEND;
          idx_nxt_s    = '0;
          shadow_nxt_s = result;
`ifdef RESULT_CHECKSUM_EN
          csum_nxt_s   = 8'h00;
`endif
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      SEND: begin
        if (xfer_s) begin
          idx_nxt_s = idx_r + IDX_W'(1);
`ifdef RESULT_CHECKSUM_EN
          // out_data_r is the byte being accepted right now.
          csum_nxt_s = csum_update(csum_r, out_data_r);
          if (idx_r == LAST_IDX) begin
            state_nxt_s = CSUM;
          end else begin
            state_nxt_s = SEND;
          end
`else
          if (idx_r == LAST_IDX) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = SEND;
          end
`endif
        end else begin
          state_nxt_s = SEND;
        end
      end
`ifdef RESULT_CHECKSUM_EN
      CSUM: begin
        if (xfer_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CSUM;
        end
      end
`endif
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so that
  // every output leaves the block straight from a flop.
  always_comb begin
    out_valid_nxt_s  = 1'b0;
    out_data_nxt_s   = 8'h00;
    busy_nxt_s       = (state_nxt_s != IDLE);
    frame_done_nxt_s = (state_nxt_s == DONE);
    case (state_nxt_s)
      SEND: begin
        out_valid_nxt_s = 1'b1;
        out_data_nxt_s  = byte_sel(shadow_nxt_s, idx_nxt_s);
      end
`ifdef RESULT_CHECKSUM_EN
      CSUM: begin
        out_valid_nxt_s = 1'b1;
        out_data_nxt_s  = csum_nxt_s;
      end
`endif
      default: begin
        out_valid_nxt_s = 1'b0;
        out_data_nxt_s  = 8'h00;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      done_q_r     <= 1'b0;
      idx_r        <= '0;
      shadow_r     <= '0;
      overrun_r    <= 1'b0;
      out_data_r   <= 8'h00;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      csum_r       <= 8'h00;
`endif
    end else begin
      state_r      <= state_nxt_s;
      done_q_r     <= mult_done;
      idx_r        <= idx_nxt_s;
      shadow_r     <= shadow_nxt_s;
      overrun_r    <= overrun_nxt_s;
      out_data_r   <= out_data_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      busy_r       <= busy_nxt_s;
      frame_done_r <= frame_done_nxt_s;
`ifdef RESULT_CHECKSUM_EN
      csum_r       <= csum_nxt_s;
`endif
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_result_streamer
//
// Self-checking bench for result_streamer. A table of frames (result pattern,
// out_ready pattern, expected frame_done cycle) is applied in a loop. A few
// hand-written sequences cover overrun, held mult_done and reset mid-frame.
// Expected bytes are pushed to a scoreboard queue when a frame is started.
// They are popped on every accepted byte.
// -----------------------------------------------------------------------------
module tb_result_streamer;

  localparam int N_ELEM = 9;
  localparam int ELEM_W = 16;
  localparam int RES_W  = N_ELEM * ELEM_W;
  localparam int N_DATA = RES_W / 8;
`ifdef RESULT_CHECKSUM_EN
  localparam int N_BYTES = N_DATA + 1;
`else
  localparam int N_BYTES = N_DATA;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             mult_done;
  logic [RES_W-1:0] result;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_done;
  logic             overrun;

  int         checks   = 0;
  int         failures = 0;
  int         fd_cnt   = 0;
  logic [7:0] sb_q[$];

  result_streamer #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mult_done  (mult_done),
    .result     (result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: push the expected byte stream of one frame.
  task automatic push_frame(input logic [RES_W-1:0] res);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int k = 0; k < N_DATA; k++) begin
      b = res[8*k +: 8];
      sb_q.push_back(b);
      x = x ^ b;
    end
`ifdef RESULT_CHECKSUM_EN
    sb_q.push_back(x);
`endif
  endtask

  // Monitor on the falling edge: every valid byte must match the scoreboard
  // head (this also proves stability during stalls); accepted bytes pop it.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          chk("stream_byte", {24'h0, out_data}, {24'h0, sb_q[0]});
          if (out_ready === 1'b1) begin
            void'(sb_q.pop_front());
          end
        end
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        chk("fd_queue_empty", sb_q.size(), 32'd0);
        chk("fd_valid_low", {31'h0, out_valid}, 32'd0);
      end
    end
  end

  typedef struct {
    logic [RES_W-1:0] res;
    logic [3:0]       rdy;
    int               exp_fd;  // 0 = timing not fixed (stalls)
    string            name;
  } vec_t;

  vec_t vecs[5];

  // Start one frame and run it to completion, checking busy and frame_done
  // timing; then confirm no re-trigger while mult_done stays high.
  task automatic run_frame(input vec_t v);
    int fd_tick;
    int i;
    result    = v.res;
    mult_done = 1'b1;
    push_frame(v.res);
    fd_tick   = 0;
    i         = 0;
    while ((fd_tick == 0) && (i < 300)) begin
      tick();
      i++;
      out_ready = v.rdy[i % 4];
      result    = ~v.res;  // capture must already be complete
      if (i == 1) begin
        chk({v.name, "_valid_t1"}, {31'h0, out_valid}, 32'd1);
      end
      chk({v.name, "_busy"}, {31'h0, busy}, 32'd1);
      if (frame_done === 1'b1) begin
        fd_tick = i;
      end
    end
    if (fd_tick == 0) begin
      chk({v.name, "_fd_timeout"}, 32'd0, 32'd1);
    end
    if (v.exp_fd != 0) begin
      chk({v.name, "_fd_cycle"}, fd_tick, v.exp_fd);
    end
    tick();
    chk({v.name, "_busy_after"}, {31'h0, busy}, 32'd0);
    chk({v.name, "_fd_pulse"}, {31'h0, frame_done}, 32'd0);
    repeat (3) tick();
    chk({v.name, "_no_retrigger"}, {31'h0, out_valid}, 32'd0);
    mult_done = 1'b0;
    tick();
    chk({v.name, "_sb_drained"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    logic [RES_W-1:0] pat_a;
    logic [RES_W-1:0] pat_e;
    logic [RES_W-1:0] pat_f;
    int               fd_tick;
    int               fd_before;

    for (int e = 0; e < N_ELEM; e++) begin
      pat_a[e*ELEM_W +: ELEM_W] = 16'(16'h0100 * e + e);
      pat_e[e*ELEM_W +: ELEM_W] = 16'(e);
    end
    pat_f = '1;

    vecs[0] = '{res: pat_a, rdy: 4'b1111, exp_fd: N_BYTES + 1, name: "basic"};
    vecs[1] = '{res: pat_a, rdy: 4'b1001, exp_fd: 0,           name: "stall"};
    vecs[2] = '{res: pat_f, rdy: 4'b1111, exp_fd: N_BYTES + 1, name: "all_ff"};
    vecs[3] = '{res: pat_e, rdy: 4'b0101, exp_fd: 0,           name: "elem_idx"};
    vecs[4] = '{res: 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5C3,
                rdy: 4'b1111, exp_fd: N_BYTES + 1, name: "mixed"};

    rst       = 1'b1;
    mult_done = 1'b0;
    out_ready = 1'b0;
    result    = '0;
    repeat (2) tick();
    chk("rst_out_data", {24'h0, out_data}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'd0);
    chk("rst_overrun", {31'h0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v]);
      tick();
    end
    chk("frames_done", fd_cnt, 32'd5);

    // Second done edge during byte 5: overrun set, frame unchanged.
    fd_before = fd_cnt;
    result    = pat_a;
    out_ready = 1'b1;
    mult_done = 1'b1;
    push_frame(pat_a);
    fd_tick   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      result = pat_f;
      if (i == 3) mult_done = 1'b0;
      if (i == 5) mult_done = 1'b1;
      if (i == 4) chk("overrun_before", {31'h0, overrun}, 32'd0);
      if (i == 7) chk("overrun_set", {31'h0, overrun}, 32'd1);
      if ((frame_done === 1'b1) && (fd_tick == 0)) fd_tick = i;
    end
    chk("overrun_fd_cycle", fd_tick, N_BYTES + 1);
    chk("overrun_sticky", {31'h0, overrun}, 32'd1);
    chk("overrun_one_frame", fd_cnt - fd_before, 32'd1);
    chk("overrun_sb_drained", sb_q.size(), 32'd0);
    mult_done = 1'b0;
    repeat (2) tick();

    // Reset asserted while byte 9 is on the bus.
    fd_before = fd_cnt;
    result    = pat_a;
    out_ready = 1'b1;
    mult_done = 1'b1;
    push_frame(pat_a);
    repeat (10) tick();
    chk("pre_rst_byte9", {24'h0, out_data}, {24'h0, pat_a[8*9 +: 8]});
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_out_data", {24'h0, out_data}, 32'd0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_overrun", {31'h0, overrun}, 32'd0);
    mult_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("postrst_idle", {31'h0, out_valid}, 32'd0);
    chk("postrst_no_fd", fd_cnt - fd_before, 32'd0);
    run_frame(vecs[4]);
    chk("postrst_one_frame", fd_cnt - fd_before, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_streamer.md
# result_streamer

Drains the packed 3x3 product matrix produced by the matrix-multiplication block and streams it out as bytes over a valid/ready handshake. It sits downstream of the multiplier (result bus and done flag) and upstream of a byte-wide sink such as a UART transmitter or debug FIFO. It captures one full result per rising edge of the done flag, then serializes all elements in a fixed order.

## Interface
- N_ELEM, 9: number of result elements per frame.
- ELEM_W, 16: element width in bits; must be a multiple of 8.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mult_done  input  1  multiplier done flag (level); a rising edge starts a frame.
- result  input  N_ELEM*ELEM_W  packed result; element e at bits [e*ELEM_W +: ELEM_W], element 0 = row 0 col 0, row-major.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  sink accepts the byte this cycle.
- busy  output  1  a frame is captured and not yet fully sent.
- frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.
- overrun  output  1  sticky; set when a done edge arrives while busy.

## Operation
- Edge detect: register done_q <= mult_done; start = mult_done & ~done_q. done_q resets to 0, so a flag already high at reset release starts a frame on the first clock.
- States: IDLE, SEND, CSUM (only with macro), DONE.
- IDLE: on start, latch result into a shadow register, clear byte index to 0, go SEND. result may change freely after the capture edge.
- SEND: out_valid=1, out_data = byte[idx] of shadow; byte order element 0 first, low byte of each element first (byte k = shadow[8k +: 8]). Transfer = out_valid & out_ready; on transfer idx increments. On transfer of byte N_ELEM*ELEM_W/8-1 (17 by default), go DONE (or CSUM).
- DONE: out_valid=0, frame_done=1 for this single cycle, return to IDLE.
- busy = 1 in SEND, CSUM, DONE; 0 in IDLE.
- start seen in any state other than IDLE: frame ignored, overrun set to 1; cleared only by rst.
- start in the IDLE cycle: captured normally even if frame_done pulsed the previous cycle.
- No arithmetic on data; bytes are passed unaltered. Index counter wide enough for N_ELEM*ELEM_W/8+1.
- rst mid-frame: immediate return to IDLE, frame discarded, no frame_done.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, frame_done=0, overrun=0, state IDLE.
- Latency: start sampled at edge t -> out_valid=1 with byte 0 from cycle t+1.
- With out_ready held 1: one byte per cycle; 18 bytes occupy cycles t+1..t+18; frame_done at t+19; next start accepted from t+20 (IDLE).
- out_valid, once high, stays high and out_data is stable until transfer (no retraction).
- out_ready low stalls indefinitely; no timeout.
- out_valid never depends combinationally on out_ready.

## Configuration
- RESULT_CHECKSUM_EN defined: after the last data byte, state CSUM sends one extra byte = XOR of all data bytes of the frame, same handshake; frame is 19 bytes; frame_done follows its acceptance.
- Undefined: no CSUM state, 18-byte frame, no checksum logic.

## Test plan
- Reset then mult_done 0->1 with result element e = 16'h0100*e + e, out_ready=1 -> bytes 00,00,01,01,02,02,...,08,08 on consecutive cycles, frame_done one cycle after byte 17, busy low after.
- Same frame with out_ready toggling 1,0,0,1 pattern -> identical byte sequence, out_data stable across every stall, no byte duplicated or skipped.
- Second mult_done rising edge during byte 5 -> overrun=1 and stays 1, current frame completes unchanged, no second frame.
- mult_done held high across a completed frame -> exactly one frame (no re-trigger without a new 0->1 edge).
- rst asserted at byte 9 -> all outputs zero immediately; next edge sends a full frame from byte 0.
- With RESULT_CHECKSUM_EN, all elements 16'hFFFF -> 18 bytes FF then checksum 00; elements 0..8 (high bytes 0) -> checksum 08.
